// File: rtl/vga_timing_monitor.sv
// Passive XGA timing checker: recovers pixel x/y from HS/VS/BLANK_N, measures line/frame geometry, and declares lock.
// Latency: pins are registered at edge N; x/y/pix_valid/meas_*/frame_done/locked update at edge N+1.
// Backpressure: none; the monitor only observes the pins and never stalls the video path.
//
// Ports:
//   clk_vga, rst                    pixel clock, synchronous active-high reset
//   vga_hs, vga_vs, vga_blank_n     monitored DAC-side pins
//   pix_valid, x, y                 registered BLANK_N and recovered coordinate (0 when blanked)
//   locked                          timing has matched expectation for LOCK_FRAMES frames
//   frame_done, frame_good          one-cycle evaluation strobe and its verdict
//   meas_*                          last latched line/frame measurements
//   err_count                       lock losses, saturating
module vga_timing_monitor #(
    parameter int unsigned H_TOTAL     = 1344,
    parameter int unsigned H_SYNC      = 136,
    parameter int unsigned H_VISIBLE   = 1024,
    parameter int unsigned V_TOTAL     = 806,
    parameter int unsigned V_SYNC      = 6,
    parameter int unsigned V_VISIBLE   = 768,
    parameter logic        POL_HS      = 1'b0,
    parameter logic        POL_VS      = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk_vga,
    input  logic        rst,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic        vga_blank_n,
    output logic        pix_valid,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        locked,
    output logic        frame_done,
    output logic        frame_good,
    output logic [11:0] meas_h_total,
    output logic [11:0] meas_h_sync,
    output logic [11:0] meas_h_vis,
    output logic [11:0] meas_v_total,
    output logic [11:0] meas_v_sync,
    output logic [11:0] meas_v_vis,
    output logic [15:0] err_count
);

    localparam logic [11:0] H_TOTAL_C = 12'(H_TOTAL);
    localparam logic [11:0] H_SYNC_C  = 12'(H_SYNC);
    localparam logic [11:0] H_VIS_C   = 12'(H_VISIBLE);
    localparam logic [11:0] V_TOTAL_C = 12'(V_TOTAL);
    localparam logic [11:0] V_SYNC_C  = 12'(V_SYNC);
    localparam logic [11:0] V_VIS_C   = 12'(V_VISIBLE);
    localparam logic [11:0] TIMEOUT_C = 12'(2 * H_TOTAL);
    localparam logic [3:0]  LOCK_C    = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    // Pin capture (stage 1) and delayed copy (stage 2)
    logic s_hs, s_vs, s_bn;
    logic s_hs_d, s_vs_d;

    // Line / frame counters
    logic [11:0] h_cnt, hs_w, vis_cnt;
    logic [11:0] line_cnt, vs_lines, vis_lines;
    logic        line_vis;
    logic        line_bad;
    logic        skip_first;

    state_t      state, state_nxt;
    logic [3:0]  good_cnt, good_nxt;
    logic        eval, err_inc;

    logic hs_act, hs_act_d, vs_act, vs_act_d;
    logic hle, hte, vle, vte;
    logic line_chk, line_err, bad_now, frame_ok, timeout;
    logic vis_first;
    logic [11:0] vis_base, vis_lines_nxt;

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            s_hs   <= 1'b0;
            s_vs   <= 1'b0;
            s_bn   <= 1'b0;
            s_hs_d <= 1'b0;
            s_vs_d <= 1'b0;
        end else begin
            s_hs   <= vga_hs;
            s_vs   <= vga_vs;
            s_bn   <= vga_blank_n;
            s_hs_d <= s_hs;
            s_vs_d <= s_vs;
        end
    end

    assign hs_act   = (s_hs == POL_HS);
    assign hs_act_d = (s_hs_d == POL_HS);
    assign vs_act   = (s_vs == POL_VS);
    assign vs_act_d = (s_vs_d == POL_VS);
    assign hle      = hs_act & ~hs_act_d;
    assign hte      = ~hs_act & hs_act_d;
    assign vle      = vs_act & ~vs_act_d;
    assign vte      = ~vs_act & vs_act_d;

    // The first line after leaving SEARCH may have been measured from an
    // arbitrary starting point, so its checks are not trusted.
    assign line_chk = hle && (state != SEARCH) && !skip_first;
    assign line_err = (sat_inc(h_cnt) != H_TOTAL_C) || (meas_h_sync != H_SYNC_C) ||
                      ((vis_cnt != 12'd0) && (vis_cnt != H_VIS_C));
    // The line ending on the vle cycle belongs to the frame being judged.
    assign bad_now  = line_bad || (line_chk && line_err);
    assign frame_ok = !bad_now && (sat_inc(line_cnt) == V_TOTAL_C) &&
                      (meas_v_sync == V_SYNC_C) && (vis_lines == V_VIS_C);
    assign timeout  = (state != SEARCH) && !hle && (h_cnt >= TIMEOUT_C);

    // A line becomes visible on its first BLANK_N-high clock, so y is taken
    // from the already-updated visible-line count.
    assign vis_first     = s_bn && (hle || !line_vis);
    assign vis_base      = vle ? 12'd0 : vis_lines;
    assign vis_lines_nxt = vis_first ? sat_inc(vis_base) : vis_base;

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        eval      = 1'b0;
        err_inc   = 1'b0;
        case (state)
            SEARCH: begin
                if (vle) begin
                    state_nxt = MEASURE;
                    good_nxt  = 4'd0;
                end
            end
            MEASURE: begin
                if (timeout) begin
                    state_nxt = SEARCH;
                end else if (vle) begin
                    eval = 1'b1;
                    if (frame_ok) begin
                        good_nxt = good_cnt + 4'd1;
                        if ((good_cnt + 4'd1) >= LOCK_C) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        good_nxt = 4'd0;
                    end
                end
            end
            LOCKED: begin
                if (timeout) begin
                    state_nxt = SEARCH;
                    err_inc   = 1'b1;
                end else if (vle) begin
                    eval = 1'b1;
                    if (!frame_ok) begin
                        state_nxt = MEASURE;
                        good_nxt  = 4'd0;
                        err_inc   = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = SEARCH;
                good_nxt  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state     <= SEARCH;
            good_cnt  <= 4'd0;
            err_count <= 16'd0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            if (err_inc && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            h_cnt        <= 12'd0;
            hs_w         <= 12'd0;
            vis_cnt      <= 12'd0;
            line_cnt     <= 12'd0;
            vs_lines     <= 12'd0;
            vis_lines    <= 12'd0;
            line_vis     <= 1'b0;
            line_bad     <= 1'b0;
            skip_first   <= 1'b0;
            meas_h_total <= 12'd0;
            meas_h_sync  <= 12'd0;
            meas_h_vis   <= 12'd0;
            meas_v_total <= 12'd0;
            meas_v_sync  <= 12'd0;
            meas_v_vis   <= 12'd0;
            pix_valid    <= 1'b0;
            x            <= 12'd0;
            y            <= 12'd0;
            frame_done   <= 1'b0;
            frame_good   <= 1'b0;
        end else begin
            // Horizontal geometry
            if (hle) begin
                h_cnt        <= 12'd0;
                meas_h_total <= sat_inc(h_cnt);
                meas_h_vis   <= vis_cnt;
                vis_cnt      <= s_bn ? 12'd1 : 12'd0;
            end else begin
                h_cnt <= sat_inc(h_cnt);
                if (s_bn) begin
                    vis_cnt <= sat_inc(vis_cnt);
                end
            end

            if (hte) begin
                meas_h_sync <= hs_w;
                hs_w        <= 12'd0;
            end else if (hs_act) begin
                hs_w <= sat_inc(hs_w);
            end

            line_vis <= hle ? s_bn : (line_vis | s_bn);

            // Vertical geometry; a coincident hle starts line 0
            if (vle) begin
                line_cnt     <= 12'd0;
                meas_v_total <= sat_inc(line_cnt);
                meas_v_vis   <= vis_lines;
                vs_lines     <= hle ? 12'd1 : 12'd0;
            end else begin
                if (hle) begin
                    line_cnt <= sat_inc(line_cnt);
                end
                if (vs_act && hle) begin
                    vs_lines <= sat_inc(vs_lines);
                end
            end

            if (vte) begin
                meas_v_sync <= vs_lines;
            end

            vis_lines <= vis_lines_nxt;

            // Frame judgement bookkeeping
            if ((state == SEARCH) || eval) begin
                line_bad <= 1'b0;
            end else if (line_chk && line_err) begin
                line_bad <= 1'b1;
            end

            if (state == SEARCH) begin
                skip_first <= 1'b1;
            end else if (hle) begin
                skip_first <= 1'b0;
            end

            frame_done <= eval;
            if (eval) begin
                frame_good <= frame_ok;
            end

            // Coordinates
            pix_valid <= s_bn;
            x         <= s_bn ? (hle ? 12'd0 : vis_cnt) : 12'd0;
            y         <= s_bn ? (vis_lines_nxt - 12'd1) : 12'd0;
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor using a reduced raster so many frames fit in a short run.
// Pixels and frame verdicts are queued when driven and compared when the monitor emits them.
// Raster: 40 clocks/line (4 sync, 6 back porch, 24 visible, 6 front), 20 lines/frame (2 sync, 3 bp, 12 vis, 3 fp).
`timescale 1ns/1ps
module tb_vga_timing_monitor;

    localparam int HT  = 40;
    localparam int HS  = 4;
    localparam int HV  = 24;
    localparam int HX0 = 10;
    localparam int VT  = 20;
    localparam int VS  = 2;
    localparam int VV  = 12;
    localparam int VY0 = 5;

    logic        clk_vga = 1'b0;
    logic        rst = 1'b1;
    logic        vga_hs = 1'b1;
    logic        vga_vs = 1'b1;
    logic        vga_blank_n = 1'b0;
    logic        pix_valid;
    logic [11:0] x, y;
    logic        locked, frame_done, frame_good;
    logic [11:0] meas_h_total, meas_h_sync, meas_h_vis;
    logic [11:0] meas_v_total, meas_v_sync, meas_v_vis;
    logic [15:0] err_count;

    vga_timing_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_VISIBLE(HV),
        .V_TOTAL(VT), .V_SYNC(VS), .V_VISIBLE(VV),
        .POL_HS(1'b0), .POL_VS(1'b0), .LOCK_FRAMES(2)
    ) dut (
        .clk_vga(clk_vga), .rst(rst),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .pix_valid(pix_valid), .x(x), .y(y),
        .locked(locked), .frame_done(frame_done), .frame_good(frame_good),
        .meas_h_total(meas_h_total), .meas_h_sync(meas_h_sync), .meas_h_vis(meas_h_vis),
        .meas_v_total(meas_v_total), .meas_v_sync(meas_v_sync), .meas_v_vis(meas_v_vis),
        .err_count(err_count)
    );

    always #5 clk_vga = ~clk_vga;

    typedef struct packed {
        logic [11:0] px;
        logic [11:0] py;
    } pix_t;

    typedef struct packed {
        logic        good;
        logic        lck;
        logic [15:0] err;
        logic [11:0] vsync;
    } frm_t;

    pix_t pix_q[$];
    frm_t frm_q[$];
    pix_t pe;
    frm_t fe;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output side of the scoreboard
    always @(negedge clk_vga) begin
        if (!rst) begin
            if (pix_valid) begin
                if (pix_q.size() == 0) begin
                    chk("pix_unexpected", 64'(pix_valid), 64'(0));
                end else begin
                    pe = pix_q.pop_front();
                    chk("pix_xy", 64'({x, y}), 64'(pe));
                end
            end else begin
                chk("blank_xy_zero", 64'({x, y}), 64'(0));
            end
            if (frame_done) begin
                if (frm_q.size() == 0) begin
                    chk("frame_done_unexpected", 64'(frame_done), 64'(0));
                end else begin
                    fe = frm_q.pop_front();
                    chk("frame_good",   64'(frame_good),   64'(fe.good));
                    chk("frame_locked", 64'(locked),       64'(fe.lck));
                    chk("frame_err",    64'(err_count),    64'(fe.err));
                    chk("meas_v_sync",  64'(meas_v_sync),  64'(fe.vsync));
                    chk("meas_v_total", 64'(meas_v_total), 64'(VT));
                    chk("meas_v_vis",   64'(meas_v_vis),   64'(VV));
                    chk("meas_h_total", 64'(meas_h_total), 64'(HT));
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, 64'({pix_valid, locked, frame_done, frame_good}), 64'(0));
        chk({tag, "_xy"},    64'({x, y}), 64'(0));
        chk({tag, "_meas_h"}, 64'({meas_h_total, meas_h_sync, meas_h_vis}), 64'(0));
        chk({tag, "_meas_v"}, 64'({meas_v_total, meas_v_sync, meas_v_vis}), 64'(0));
        chk({tag, "_err"},   64'(err_count), 64'(0));
    endtask

    // One frame of raster. When ev is set, the vle at its start evaluates the
    // previous frame and the expected verdict is queued.
    task automatic run_frame(input bit ev, input bit egood, input bit elck, input int eerr,
                             input int evs, input int vs_len, input int long_line, input int rst_line);
        frm_t f;
        for (int ln = 0; ln < VT; ln++) begin
            for (int h = 0; h < ((ln == long_line) ? HT + 1 : HT); h++) begin
                @(posedge clk_vga);
                #1;
                vga_hs      = (h < HS) ? 1'b0 : 1'b1;
                vga_vs      = (ln < vs_len) ? 1'b0 : 1'b1;
                vga_blank_n = (ln >= VY0) && (ln < VY0 + VV) && (h >= HX0) && (h < HX0 + HV);
                if (vga_blank_n) begin
                    pix_q.push_back({12'(h - HX0), 12'(ln - VY0)});
                end
                if (ev && ln == 0 && h == 0) begin
                    f.good  = egood;
                    f.lck   = elck;
                    f.err   = 16'(eerr);
                    f.vsync = 12'(evs);
                    frm_q.push_back(f);
                end
                if (ln == rst_line && h == 10) begin
                    rst = 1'b1;
                end
                if (ln == rst_line && h == 11) begin
                    chk_all_zero("midframe_rst");
                    pix_q.delete();
                    rst = 1'b0;
                end
                if (ln == VY0 + 6 && h == 3) begin
                    chk("line_h_total", 64'(meas_h_total), 64'(HT));
                    chk("line_h_sync",  64'(meas_h_sync),  64'(HS));
                    chk("line_h_vis",   64'(meas_h_vis),   64'(HV));
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_vga);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (5) @(posedge clk_vga);

        // Nominal acquisition: first vle unevaluated, lock on the second verdict
        //        ev good lck err vsync vs_len long rst
        run_frame(0, 0, 0, 0, 0, VS, -1, -1);
        run_frame(1, 1, 0, 0, VS, VS, -1, -1);
        run_frame(1, 1, 1, 0, VS, VS, -1, -1);

        // One 41-clock line while locked
        run_frame(1, 1, 1, 0, VS, VS, 8, -1);
        run_frame(1, 0, 0, 1, VS, VS, -1, -1);
        run_frame(1, 1, 0, 1, VS, VS, -1, -1);
        run_frame(1, 1, 1, 1, VS, VS, -1, -1);

        // HS stops after a complete frame: lock must hold until h_cnt reaches 2*H_TOTAL
        @(posedge clk_vga);
        #1;
        vga_hs      = 1'b1;
        vga_vs      = 1'b1;
        vga_blank_n = 1'b0;
        repeat (42) @(posedge clk_vga);
        #1;
        chk("hs_stop_locked_hold", 64'(locked), 64'(1));
        @(posedge clk_vga);
        #1;
        chk("hs_stop_locked_drop", 64'(locked), 64'(0));
        chk("hs_stop_err", 64'(err_count), 64'(2));
        repeat (20) @(posedge clk_vga);

        // Resumed timing relocks on the third vle
        run_frame(0, 0, 0, 0, 0, VS, -1, -1);
        run_frame(1, 1, 0, 2, VS, VS, -1, -1);
        run_frame(1, 1, 1, 2, VS, VS, -1, -1);

        // Five-line VS pulse
        run_frame(1, 1, 1, 2, VS, 5, -1, -1);
        run_frame(1, 0, 0, 3, 5, VS, -1, -1);
        run_frame(1, 1, 0, 3, VS, VS, -1, -1);

        // Reset mid-frame while locked, then full reacquisition
        run_frame(1, 1, 1, 3, VS, VS, -1, 1);
        run_frame(0, 0, 0, 0, 0, VS, -1, -1);
        run_frame(1, 1, 0, 0, VS, VS, -1, -1);
        run_frame(1, 1, 1, 0, VS, VS, -1, -1);

        @(posedge clk_vga);
        #1;
        vga_hs      = 1'b1;
        vga_vs      = 1'b1;
        vga_blank_n = 1'b0;
        repeat (5) @(posedge clk_vga);
        #1;
        chk("final_locked", 64'(locked), 64'(1));
        chk("pixels_pending", 64'(pix_q.size()), 64'(0));
        chk("frames_pending", 64'(frm_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
